fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pcstall  input  1  from hazardUnit; hold PC.
REQ-006 SHALL have port IF_IDstall  input  1  from hazardUnit; hold IF/ID register.
REQ-007 SHALL have port flushIF_ID  input  1  from hazardUnit; bubble IF/ID.
REQ-008 SHALL have port PCSrc  input  1  taken-branch redirect.
REQ-009 SHALL have port branch_target  input  16  branch redirect address.
REQ-010 SHALL have port jump  input  1  jump redirect.
REQ-011 SHALL have port jump_target  input  16  jump redirect address.
REQ-012 SHALL have port imem_addr  output  16  instruction memory word address.
REQ-013 SHALL have port imem_req  output  1  fetch request.
REQ-014 SHALL have port imem_ready  input  1  memory accepts request and returns data this cycle.
REQ-015 SHALL have port imem_rdata  input  16  instruction word, valid when imem_req && imem_ready.
REQ-016 SHALL have port instrD  output  16  IF/ID instruction.
REQ-017 SHALL have port pcPlus1D  output  16  IF/ID PC+1.
REQ-018 SHALL have port validD  output  1  IF/ID holds a real instruction.
REQ-019 SHALL have port fetch_state  output  2  current FSM state.

Function
REQ-020 SHALL implement FSM states FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2; fetch_state mirrors the state.
REQ-021 SHALL drive imem_req=1 in FETCH and DRAIN, and 0 in HOLD.
REQ-022 SHALL drive imem_addr=PC; PC and imem_addr stay stable while imem_req=1 and imem_ready=0.
REQ-023 SHALL treat a transfer as imem_req && imem_ready; latency from transfer to instrD update is 1 edge.
REQ-024 SHALL define adv = !pcstall && !IF_IDstall, and redir = PCSrc || jump, with target = PCSrc ? branch_target : jump_target (branch wins when both are set).
REQ-025 In FETCH, on a transfer with adv and !redir, SHALL set instrD<=imem_rdata, pcPlus1D<=PC+1, validD<=1, PC<=PC+1, and stay in FETCH.
REQ-026 In FETCH, on a transfer with !adv and !redir, SHALL copy imem_rdata to a hold buffer, keep PC, and go to HOLD.
REQ-027 In HOLD, when adv and !redir, SHALL load the buffer into IF/ID with pcPlus1D=PC+1, set PC<=PC+1, and go to FETCH.
REQ-028 On redir in FETCH with a transfer, or in HOLD, SHALL discard the data, set PC<=target, and go to (or stay in) FETCH.
REQ-029 On redir in FETCH without a transfer, SHALL save target, keep imem_addr, and go to DRAIN.
REQ-030 In DRAIN, on a transfer SHALL discard the data, set PC<=saved target, and go to FETCH.
REQ-031 In DRAIN, a new redir SHALL overwrite the saved target.
REQ-032 Redirect SHALL take priority over pcstall and IF_IDstall.
REQ-033 flushIF_ID SHALL force validD<=0 and instrD<=16'h0000 on the next edge, overriding IF_IDstall and any load; PC behaviour is unaffected.
REQ-034 When IF/ID is not loaded and not flushed, instrD, pcPlus1D and validD SHALL hold their values.
REQ-035 PC+1 SHALL wrap from 16'hFFFF to 16'h0000.

Reset
REQ-036 While rst=0, SHALL set PC=RESET_PC, state=FETCH, instrD=0, pcPlus1D=0, validD=0, hold buffer=0 and saved target=0, and force imem_req=0.
REQ-037 Reset mid-transaction SHALL abandon the outstanding request; the memory shares the same reset.
REQ-038 On the first edge after rst rises, SHALL assert imem_req with imem_addr=RESET_PC.

Verification
REQ-039 Reset release, imem_ready=1, rdata=16'h1111, 16'h2222 -> instrD=16'h1111, pcPlus1D=1, then instrD=16'h2222, pcPlus1D=2, validD=1.
REQ-040 pcstall=1 at a transfer of 16'hABCD -> state HOLD, imem_req=0, PC unchanged; pcstall=0 -> instrD=16'hABCD next edge, then FETCH.
REQ-041 imem_ready=0, PCSrc=1, branch_target=16'h0040 -> DRAIN, imem_addr unchanged; ready=1 -> data dropped (validD unchanged), next imem_addr=16'h0040.
REQ-042 PCSrc=1 with target 16'h0010 and jump=1 with target 16'h0020 in the same cycle -> PC=16'h0010.
REQ-043 PC=16'hFFFF with a transfer -> pcPlus1D=16'h0000 and next imem_addr=16'h0000.
REQ-044 flushIF_ID=1 with IF_IDstall=1 -> validD=0, instrD=0; rst=0 mid-DRAIN -> imem_req=0 immediately, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a single-word request/ready memory handshake,
//   a one-entry hold buffer for words that arrive while the pipe is stalled,
//   and a drain state that keeps an outstanding request stable when a
//   redirect shows up before the memory has answered.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   pcstall        hold PC (hazard unit)
//   IF_IDstall     hold IF/ID register (hazard unit)
//   flushIF_ID     bubble IF/ID on the next edge
//   PCSrc          taken-branch redirect, target on branch_target
//   jump           jump redirect, target on jump_target
//   imem_addr      instruction memory word address (= PC)
//   imem_req       fetch request
//   imem_ready     memory accepts request / returns data this cycle
//   imem_rdata     instruction word, valid on imem_req && imem_ready
//   instrD         IF/ID instruction
//   pcPlus1D       IF/ID PC+1
//   validD         IF/ID holds a real instruction
//   fetch_state    FSM state (0 FETCH, 1 HOLD, 2 DRAIN)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcstall,
    input  logic        IF_IDstall,
    input  logic        flushIF_ID,
    input  logic        PCSrc,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instrD,
    output logic [15:0] pcPlus1D,
    output logic        validD,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_hbuf;     // word captured while the pipe was stalled
    logic [15:0] r_tgt;      // redirect target waiting for the in-flight fetch
    logic [15:0] r_instr;
    logic [15:0] r_pc1;
    logic        r_valid;

    logic        w_xfer;
    logic        w_adv;
    logic        w_redir;
    logic [15:0] w_target;
    logic [15:0] w_pc_inc;
    logic        w_load;
    logic [15:0] w_word;

    // The request is gated by reset so an in-flight fetch is dropped the
    // moment reset asserts rather than at the next edge.
    assign imem_req    = rst && (r_state != HOLD);
    assign imem_addr   = r_pc;
    assign instrD      = r_instr;
    assign pcPlus1D    = r_pc1;
    assign validD      = r_valid;
    assign fetch_state = r_state;

    assign w_xfer   = imem_req && imem_ready;
    assign w_adv    = !pcstall && !IF_IDstall;
    assign w_redir  = PCSrc || jump;
    assign w_target = PCSrc ? branch_target : jump_target;
    assign w_pc_inc = r_pc + 16'd1;   // wraps naturally at 16 bits

    // IF/ID is loaded either straight from memory or from the hold buffer.
    // A redirect always wins, so a load never happens alongside one.
    assign w_load = !w_redir && w_adv &&
                    (((r_state == FETCH) && w_xfer) || (r_state == HOLD));
    assign w_word = (r_state == HOLD) ? r_hbuf : imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_hbuf  <= 16'h0000;
            r_tgt   <= 16'h0000;
            r_instr <= 16'h0000;
            r_pc1   <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            // Flush beats both a stall and a load; PC+1 is left alone.
            if (flushIF_ID) begin
                r_instr <= 16'h0000;
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_instr <= w_word;
                r_pc1   <= w_pc_inc;
                r_valid <= 1'b1;
            end

            case (r_state)
                FETCH: begin
                    if (w_redir) begin
                        if (w_xfer) begin
                            r_pc <= w_target;
                        end else begin
                            // Request still outstanding: keep the address
                            // stable and redirect once it completes.
                            r_tgt   <= w_target;
                            r_state <= DRAIN;
                        end
                    end else if (w_xfer) begin
                        if (w_adv) begin
                            r_pc <= w_pc_inc;
                        end else begin
                            r_hbuf  <= imem_rdata;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_redir) begin
                        r_pc    <= w_target;
                        r_state <= FETCH;
                    end else if (w_adv) begin
                        r_pc    <= w_pc_inc;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        // A redirect arriving on the completing cycle is the
                        // newest one, so it takes over the saved target.
                        r_pc    <= w_redir ? w_target : r_tgt;
                        r_state <= FETCH;
                    end else if (w_redir) begin
                        r_tgt <= w_target;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule
